// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm trigger: FSM encoding, BCD time field
// layout and the encodings reported on ring_id.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  // BCD time layout: {hour, minute, second}, one byte each
  localparam int FIELD_W  = 8;
  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  localparam logic [1:0] ID_ALARM1 = 2'd0;
  localparam logic [1:0] ID_ALARM2 = 2'd1;
  localparam logic [1:0] ID_ALARM3 = 2'd2;

  // Exact equality, field by field; digits are not checked for BCD validity
  function automatic logic time_eq(input logic [23:0] a, input logic [23:0] b);
    return (a[HOUR_LSB +: FIELD_W] == b[HOUR_LSB +: FIELD_W]) &&
           (a[MIN_LSB  +: FIELD_W] == b[MIN_LSB  +: FIELD_W]) &&
           (a[SEC_LSB  +: FIELD_W] == b[SEC_LSB  +: FIELD_W]);
  endfunction

endpackage

// File: rtl/alarm_match.sv
// Three-way alarm/time comparator with fixed priority alarm1 > alarm2 > alarm3.
module alarm_match
  import alarm_pkg::*;
(
  input  logic [23:0] cur_time,
  input  logic [23:0] alarm1_time,
  input  logic [23:0] alarm2_time,
  input  logic [23:0] alarm3_time,
  input  logic [2:0]  alarm_en,
  output logic        hit,
  output logic [1:0]  hit_id
);

  logic [2:0] eq;

  // Per-alarm enabled match, then pick the lowest-numbered winner
  always_comb begin
    eq[0]  = alarm_en[0] && time_eq(cur_time, alarm1_time);
    eq[1]  = alarm_en[1] && time_eq(cur_time, alarm2_time);
    eq[2]  = alarm_en[2] && time_eq(cur_time, alarm3_time);
    hit    = |eq;
    hit_id = ID_ALARM1;
    if (eq[0])      hit_id = ID_ALARM1;
    else if (eq[1]) hit_id = ID_ALARM2;
    else if (eq[2]) hit_id = ID_ALARM3;
  end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: starts ringing on an enabled alarm match, supports a bounded
// number of snoozes and auto-stops after RING_SECS seconds of ringing.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for an enabled alarm to match on a sec_tick
// ST_RINGING | ring=1, buzzer toggles each second, ring counter runs up
// ST_SNOOZE  | silent, snooze counter runs down to the next ring
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sec_tick,
  input  logic [23:0] cur_time,
  input  logic [23:0] alarm1_time,
  input  logic [23:0] alarm2_time,
  input  logic [23:0] alarm3_time,
  input  logic [2:0]  alarm_en,
  input  logic        stop_pulse,
  input  logic        snooze_pulse,
  output logic        ring,
  output logic        buzzer,
  output logic [1:0]  ring_id,
  output logic        snoozing,
  output logic [1:0]  snooze_left
);

  // A one-second ring would give a zero-width counter; keep at least one bit
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int SW = $clog2(SNOOZE_SECS + 1);

  state_t          state, state_n;
  logic [RW-1:0]   ring_cnt, ring_cnt_n;
  logic [SW-1:0]   snz_cnt, snz_cnt_n;
  logic            buzzer_q, buzzer_n;
  logic [1:0]      ring_id_q, ring_id_n;
  logic [1:0]      snz_left_q, snz_left_n;
  logic            hit;
  logic [1:0]      hit_id;
  logic            cur_en;

  alarm_match u_match (
    .cur_time    (cur_time),
    .alarm1_time (alarm1_time),
    .alarm2_time (alarm2_time),
    .alarm3_time (alarm3_time),
    .alarm_en    (alarm_en),
    .hit         (hit),
    .hit_id      (hit_id)
  );

  // Enable bit of the alarm currently owning the event
  always_comb begin
    cur_en = 1'b0;
    case (ring_id_q)
      ID_ALARM1: cur_en = alarm_en[0];
      ID_ALARM2: cur_en = alarm_en[1];
      ID_ALARM3: cur_en = alarm_en[2];
      default:   cur_en = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts any event in progress
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      buzzer_q   <= 1'b0;
      ring_id_q  <= ID_ALARM1;
      snz_left_q <= 2'd0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      snz_cnt    <= snz_cnt_n;
      buzzer_q   <= buzzer_n;
      ring_id_q  <= ring_id_n;
      snz_left_q <= snz_left_n;
    end
  end

  // Next-state logic; priority is disable/stop, then snooze, then sec_tick
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    buzzer_n   = buzzer_q;
    ring_id_n  = ring_id_q;
    snz_left_n = snz_left_q;
    case (state)
      ST_IDLE: begin
        buzzer_n = 1'b0;
        if (sec_tick && hit) begin
          state_n    = ST_RINGING;
          ring_id_n  = hit_id;
          ring_cnt_n = '0;
          buzzer_n   = 1'b1;
          snz_left_n = 2'(MAX_SNOOZE);
        end
      end
      ST_RINGING: begin
        if (!cur_en || stop_pulse) begin
          state_n  = ST_IDLE;
          buzzer_n = 1'b0;
        end else if (snooze_pulse) begin
          buzzer_n = 1'b0;
          if (snz_left_q != 2'd0) begin
            state_n    = ST_SNOOZE;
            snz_cnt_n  = SW'(SNOOZE_SECS);
            snz_left_n = snz_left_q - 2'd1;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (sec_tick) begin
          if (ring_cnt == RW'(RING_SECS - 1)) begin
            state_n  = ST_IDLE;
            buzzer_n = 1'b0;
          end else begin
            ring_cnt_n = ring_cnt + 1'b1;
            buzzer_n   = ~buzzer_q;
          end
        end
      end
      ST_SNOOZE: begin
        buzzer_n = 1'b0;
        if (!cur_en || stop_pulse) begin
          state_n = ST_IDLE;
        end else if (sec_tick) begin
          if (snz_cnt == SW'(1)) begin
            state_n    = ST_RINGING;
            ring_cnt_n = '0;
            buzzer_n   = 1'b1;
          end else begin
            snz_cnt_n = snz_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        buzzer_n = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers so reset forces them low cleanly
  always_comb begin
    ring        = (state == ST_RINGING);
    snoozing    = (state == ST_SNOOZE);
    buzzer      = buzzer_q;
    ring_id     = ring_id_q;
    snooze_left = snz_left_q;
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with RING_SECS=4, SNOOZE_SECS=3,
// MAX_SNOOZE=2. Expected outputs are queued when a cycle is driven and
// compared after the clock edge that should produce them.
module tb_alarm_trigger;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sec_tick;
  logic [23:0] cur_time;
  logic [23:0] alarm1_time, alarm2_time, alarm3_time;
  logic [2:0]  alarm_en;
  logic        stop_pulse;
  logic        snooze_pulse;
  logic        ring;
  logic        buzzer;
  logic [1:0]  ring_id;
  logic        snoozing;
  logic [1:0]  snooze_left;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;
  sb_t sb_q[$];

  alarm_trigger #(
    .RING_SECS   (4),
    .SNOOZE_SECS (3),
    .MAX_SNOOZE  (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sec_tick     (sec_tick),
    .cur_time     (cur_time),
    .alarm1_time  (alarm1_time),
    .alarm2_time  (alarm2_time),
    .alarm3_time  (alarm3_time),
    .alarm_en     (alarm_en),
    .stop_pulse   (stop_pulse),
    .snooze_pulse (snooze_pulse),
    .ring         (ring),
    .buzzer       (buzzer),
    .ring_id      (ring_id),
    .snoozing     (snoozing),
    .snooze_left  (snooze_left)
  );

  always #5 clk = ~clk;

  // Packs {ring, buzzer, ring_id, snoozing, snooze_left}
  function automatic logic [6:0] ex(input bit r, input bit b, input logic [1:0] id,
                                    input bit s, input logic [1:0] left);
    return {r, b, id, s, left};
  endfunction

  // Drive one cycle of pulses, queue the expectation, check after the edge
  task automatic cyc(input bit t, input bit st, input bit sz,
                     input logic [6:0] exp, input string tag);
    sb_t e;
    logic [6:0] got;
    sec_tick     = t;
    stop_pulse   = st;
    snooze_pulse = sz;
    sb_q.push_back('{tag: tag, exp: exp});
    @(posedge clk);
    #1;
    sec_tick     = 1'b0;
    stop_pulse   = 1'b0;
    snooze_pulse = 1'b0;
    got = {ring, buzzer, ring_id, snoozing, snooze_left};
    e = sb_q.pop_front();
    checks++;
    assert (got === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, got, e.exp);
      end
  endtask

  initial begin
    reset_n      = 1'b0;
    sec_tick     = 1'b0;
    stop_pulse   = 1'b0;
    snooze_pulse = 1'b0;
    cur_time     = 24'h000000;
    alarm1_time  = 24'h000000;
    alarm2_time  = 24'h000000;
    alarm3_time  = 24'h000000;
    alarm_en     = 3'b000;
    #2;

    // Reset
    cyc(0, 0, 0, ex(0, 0, 2'd0, 0, 2'd0), "reset0");
    cyc(1, 0, 0, ex(0, 0, 2'd0, 0, 2'd0), "reset1");
    reset_n = 1'b1;

    // Basic ring and auto-stop after 4 ticks
    alarm1_time = 24'h073000;
    alarm_en    = 3'b001;
    cur_time    = 24'h072959;
    cyc(1, 0, 0, ex(0, 0, 2'd0, 0, 2'd0), "pre_match");
    cur_time = 24'h073000;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "ring_on");
    cyc(0, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "ring_hold");
    cur_time = 24'h073001;
    cyc(1, 0, 0, ex(1, 0, 2'd0, 0, 2'd2), "buz_t1");
    cur_time = 24'h073002;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "buz_t2");
    cur_time = 24'h073003;
    cyc(1, 0, 0, ex(1, 0, 2'd0, 0, 2'd2), "buz_t3");
    cur_time = 24'h073004;
    cyc(1, 0, 0, ex(0, 0, 2'd0, 0, 2'd2), "auto_stop");
    cur_time = 24'h073005;
    cyc(1, 0, 0, ex(0, 0, 2'd0, 0, 2'd2), "idle_after");

    // Priority and enable
    alarm1_time = 24'h120000;
    alarm2_time = 24'h110000;
    alarm3_time = 24'h120000;
    alarm_en    = 3'b101;
    cur_time    = 24'h120000;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "prio_a1");
    cyc(0, 1, 0, ex(0, 0, 2'd0, 0, 2'd2), "prio_stop1");
    alarm_en = 3'b100;
    cyc(1, 0, 0, ex(1, 1, 2'd2, 0, 2'd2), "prio_a3");
    cyc(0, 1, 0, ex(0, 0, 2'd2, 0, 2'd2), "prio_stop3");
    alarm_en = 3'b000;
    cyc(1, 0, 0, ex(0, 0, 2'd2, 0, 2'd2), "all_disabled");

    // Snooze chain
    alarm1_time = 24'h060000;
    alarm_en    = 3'b001;
    cur_time    = 24'h060000;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "snz_ring");
    cyc(0, 0, 1, ex(0, 0, 2'd0, 1, 2'd1), "snz1_enter");
    cur_time = 24'h060001;
    cyc(1, 0, 0, ex(0, 0, 2'd0, 1, 2'd1), "snz1_t1");
    cyc(1, 0, 0, ex(0, 0, 2'd0, 1, 2'd1), "snz1_t2");
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd1), "snz1_rering");
    cyc(1, 0, 0, ex(1, 0, 2'd0, 0, 2'd1), "rering_tick");
    cyc(0, 0, 1, ex(0, 0, 2'd0, 1, 2'd0), "snz2_enter");
    cyc(1, 0, 0, ex(0, 0, 2'd0, 1, 2'd0), "snz2_t1");
    cyc(0, 0, 1, ex(0, 0, 2'd0, 1, 2'd0), "snz_in_snooze");
    cyc(1, 0, 0, ex(0, 0, 2'd0, 1, 2'd0), "snz2_t2");
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd0), "snz2_rering");
    cyc(0, 0, 1, ex(0, 0, 2'd0, 0, 2'd0), "snz3_idle");

    // Stop beats snooze beats tick
    alarm1_time = 24'h080000;
    cur_time    = 24'h080000;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "both_ring");
    cyc(1, 1, 1, ex(0, 0, 2'd0, 0, 2'd2), "stop_snz_tick");
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "rearm_ring");
    cyc(1, 0, 1, ex(0, 0, 2'd0, 1, 2'd1), "snz_beats_tick");
    cur_time = 24'h080001;
    cyc(1, 0, 0, ex(0, 0, 2'd0, 1, 2'd1), "snz_count");

    // Disable mid-snooze
    alarm_en = 3'b000;
    cyc(0, 0, 0, ex(0, 0, 2'd0, 0, 2'd1), "disable_snz");

    // Reset mid-ring
    alarm_en    = 3'b001;
    alarm1_time = 24'h090000;
    cur_time    = 24'h090000;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "rst_ring");
    cur_time = 24'h090001;
    cyc(1, 0, 0, ex(1, 0, 2'd0, 0, 2'd2), "rst_tick");
    reset_n = 1'b0;
    cyc(0, 0, 0, ex(0, 0, 2'd0, 0, 2'd0), "rst_abort");
    reset_n = 1'b1;

    // No false match across midnight
    alarm1_time = 24'h000000;
    cur_time    = 24'h235959;
    cyc(1, 0, 0, ex(0, 0, 2'd0, 0, 2'd0), "no_false");
    cur_time = 24'h000000;
    cyc(1, 0, 0, ex(1, 1, 2'd0, 0, 2'd2), "midnight");
    cyc(0, 1, 0, ex(0, 0, 2'd0, 0, 2'd2), "midnight_stop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameter RING_SECS, default 60, number of sec_tick pulses a ring lasts before auto-stop.
REQ-002 Parameter SNOOZE_SECS, default 300, number of sec_tick pulses spent in snooze before re-ringing.
REQ-003 Parameter MAX_SNOOZE, default 3, number of snoozes allowed per alarm event.
REQ-004 clk  in  1  system clock.
REQ-005 reset_n  in  1  synchronous, active-low reset; clock clk.
REQ-006 sec_tick  in  1  one-cycle pulse, once per second, asserted in the cycle the current time becomes valid.
REQ-007 cur_time  in  24  current time, BCD {hour[23:16], minute[15:8], second[7:0]}.
REQ-008 alarm1_time, alarm2_time, alarm3_time  in  24 each  alarm setpoints, same BCD layout.
REQ-009 alarm_en  in  3  per-alarm enable; bit0 = alarm1.
REQ-010 stop_pulse  in  1  one-cycle stop request.
REQ-011 snooze_pulse  in  1  one-cycle snooze request.
REQ-012 ring  out  1  high while ringing.
REQ-013 buzzer  out  1  audible pattern; toggles each second while ringing.
REQ-014 ring_id  out  2  active alarm: 0 = alarm1, 1 = alarm2, 2 = alarm3; holds during SNOOZE.
REQ-015 snoozing  out  1  high in SNOOZE.
REQ-016 snooze_left  out  2  remaining snoozes for the current event.

Function
REQ-017 States: IDLE, RINGING, SNOOZE, all registered.
REQ-018 IDLE: in a cycle with sec_tick=1, any enabled alarm whose 24-bit time equals cur_time is a match; next cycle the block enters RINGING.
REQ-019 Match priority: alarm1 > alarm2 > alarm3; ring_id takes the winning index.
REQ-020 Comparison: exact 24-bit equality; no BCD validity check; 00:00:00 is a legal alarm time.
REQ-021 Match entry: ring=1, buzzer=1, ring counter=0, snooze_left=MAX_SNOOZE.
REQ-022 RINGING, each sec_tick: buzzer inverts and the ring counter increments.
REQ-023 RINGING auto-stop: a sec_tick while the counter equals RING_SECS-1 returns the block to IDLE next cycle.
REQ-024 RINGING, stop_pulse: IDLE next cycle.
REQ-025 RINGING, snooze_pulse with snooze_left>0: SNOOZE next cycle; snooze counter=SNOOZE_SECS; snooze_left decrements.
REQ-026 RINGING, snooze_pulse with snooze_left=0: same behaviour as stop_pulse.
REQ-027 SNOOZE outputs: ring=0, buzzer=0, snoozing=1.
REQ-028 SNOOZE, each sec_tick: the snooze counter decrements.
REQ-029 SNOOZE, sec_tick while the counter equals 1: RINGING next cycle, with ring counter=0 and buzzer=1.
REQ-030 SNOOZE, stop_pulse: IDLE; snooze_pulse is ignored.
REQ-031 Simultaneous events: stop_pulse beats snooze_pulse, which beats sec_tick.
REQ-032 Entering IDLE from any state: ring=0, buzzer=0, snoozing=0; ring_id holds its last value.
REQ-033 Clearing alarm_en[ring_id] in RINGING or SNOOZE: IDLE next cycle.
REQ-034 Matches arriving in RINGING or SNOOZE are ignored and not queued.
REQ-035 Retrigger guard: a match in the sec_tick cycle that returns the block to IDLE is not taken; re-arm happens on the following sec_tick.
REQ-036 Stop or auto-stop inside the matching second: no retrigger, since cur_time has already advanced by the next sec_tick.
REQ-037 Counter widths: $clog2(RING_SECS) for the ring counter, $clog2(SNOOZE_SECS+1) for the snooze counter; no wrap-around is reachable.

Reset
REQ-038 While reset_n=0 at a clk edge: state=IDLE; all counters 0; ring, buzzer, snoozing 0; ring_id=0; snooze_left=0.
REQ-039 Reset asserted mid-ring or mid-snooze aborts the event, with no output glitch after the edge.

Structure
REQ-040 Package alarm_pkg holds: state encoding, BCD field offsets (HOUR 23:16, MIN 15:8, SEC 7:0), the ring_id encodings.
REQ-041 One sub-module, alarm_match: combinational 3-way equality plus priority encoder; outputs hit and hit_id.
REQ-042 No other hierarchy.

Verification (RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2 unless stated)
REQ-043 Basic ring: alarm1=07:30:00, en=001, tick at cur_time 07:30:00 -> ring=1, ring_id=0 next cycle; buzzer 1,0,1,0; after the 4th tick -> ring=0.
REQ-044 Priority and enable: alarm1=alarm3=12:00:00, en=101 -> ring_id=0; en=100 -> ring_id=2; en=000 -> no ring.
REQ-045 Snooze chain: ring, snooze -> snoozing=1 for 3 ticks, ring again with snooze_left=1; snooze -> again; third snooze -> IDLE.
REQ-046 Simultaneous stop+snooze in RINGING -> IDLE, snooze_left unchanged.
REQ-047 Disable and reset: clear alarm_en[0] mid-SNOOZE -> IDLE next cycle; assert reset_n=0 mid-RINGING -> all outputs 0 on the next edge.
REQ-048 No false match: cur_time 23:59:59 vs alarm 00:00:00 -> no ring; next tick at 00:00:00 -> ring.
